if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_if.sv | 29 ++
 rtl/if_fetch.sv | 115 +++++++++++
 tb/tb_if_fetch.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: stall/redirect controls, ROM port and IF/ID outputs.
// slave = fetch unit, master = surrounding pipeline/ROM.
interface if_fetch_if;
  logic        stall_if_i;
  logic        stall_id_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        misalign_o;
  logic [31:0] trap_pc_o;
  logic [31:0] fetch_cnt_o;

  modport slave (
    input  stall_if_i, stall_id_i, branch_flag_i, branch_target_i, rom_inst_i,
    output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o,
           misalign_o, trap_pc_o, fetch_cnt_o
  );

  modport master (
    output stall_if_i, stall_id_i, branch_flag_i, branch_target_i, rom_inst_i,
    input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o,
           misalign_o, trap_pc_o, fetch_cnt_o
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch with IF/ID register: one instruction per cycle from a zero-wait ROM.
// Stalls hold PC (and IF/ID on stall_id); redirects flush; misaligned redirect freezes in TRAP.
module if_fetch #(
  parameter logic [31:0] START_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        rom_ce_q, rom_ce_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= START_PC;
      rom_ce_q    <= 1'b0;
      id_pc_q     <= 32'h0;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      trap_pc_q   <= 32'h0;
      fetch_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rom_ce_q    <= rom_ce_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
      misalign_q  <= misalign_d;
      trap_pc_q   <= trap_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rom_ce_d    = rom_ce_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    misalign_d  = misalign_q;
    trap_pc_d   = trap_pc_q;
    fetch_cnt_d = fetch_cnt_q;

    unique case (state_q)
      IDLE: begin
        state_d  = FETCH;
        rom_ce_d = 1'b1;
        pc_d     = START_PC;
      end

      FETCH: begin
        // Redirect beats both stalls; the wrong-path word in IF/ID is squashed.
        if (bus.branch_flag_i) begin
          id_pc_d    = 32'h0;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
          if (bus.branch_target_i[1:0] != 2'b00) begin
            // PC is left alone so the ROM never sees a misaligned address.
            state_d    = TRAP;
            rom_ce_d   = 1'b0;
            misalign_d = 1'b1;
            trap_pc_d  = bus.branch_target_i;
          end else begin
            pc_d = bus.branch_target_i;
          end
        end else if (bus.stall_id_i) begin
          pc_d = pc_q;
        end else if (bus.stall_if_i) begin
          id_pc_d    = pc_q;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
        end else begin
          id_pc_d     = pc_q;
          id_inst_d   = bus.rom_inst_i;
          id_valid_d  = 1'b1;
          pc_d        = pc_q + 32'd4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end

      TRAP: begin
        state_d = TRAP;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rom_ce_o    = rom_ce_q;
  assign bus.rom_addr_o  = pc_q;
  assign bus.id_pc_o     = id_pc_q;
  assign bus.id_inst_o   = id_inst_q;
  assign bus.id_valid_o  = id_valid_q;
  assign bus.misalign_o  = misalign_q;
  assign bus.trap_pc_o   = trap_pc_q;
  assign bus.fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: main instance at START_PC=0, second at START_PC=FFFF_FFF8 for PC wrap.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  if_fetch_if fb0 ();
  if_fetch_if fb1 ();

  if_fetch #(.START_PC(32'h0000_0000), .NOP_INST(NOP)) dut0 (.clk(clk), .rst(rst), .bus(fb0));
  if_fetch #(.START_PC(32'hFFFF_FFF8), .NOP_INST(NOP)) dut1 (.clk(clk), .rst(rst), .bus(fb1));

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return a ^ 32'h5A5A_0000;
  endfunction

  assign fb0.rom_inst_i = fb0.rom_ce_o ? rom_word(fb0.rom_addr_o) : 32'h0;
  assign fb1.rom_inst_i = fb1.rom_ce_o ? rom_word(fb1.rom_addr_o) : 32'h0;
  assign fb1.stall_if_i = 1'b0;
  assign fb1.stall_id_i = 1'b0;
  assign fb1.branch_flag_i = 1'b0;
  assign fb1.branch_target_i = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sif, input logic sid, input logic br, input logic [31:0] tgt);
    fb0.stall_if_i = sif;
    fb0.stall_id_i = sid;
    fb0.branch_flag_i = br;
    fb0.branch_target_i = tgt;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic vld, input logic [31:0] cnt);
    chk({tag, "_id_pc"}, fb0.id_pc_o, pc);
    chk({tag, "_id_inst"}, fb0.id_inst_o, inst);
    chk({tag, "_id_valid"}, {31'h0, fb0.id_valid_o}, {31'h0, vld});
    chk({tag, "_cnt"}, fb0.fetch_cnt_o, cnt);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ce"}, {31'h0, fb0.rom_ce_o}, 32'h0);
    chk({tag, "_addr"}, fb0.rom_addr_o, 32'h0);
    chk_id(tag, 32'h0, NOP, 1'b0, 32'h0);
    chk({tag, "_mis"}, {31'h0, fb0.misalign_o}, 32'h0);
    chk({tag, "_tpc"}, fb0.trap_pc_o, 32'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    // Reset wins over a simultaneous redirect and stall.
    drive(1'b1, 1'b1, 1'b1, 32'h40);
    tick();
    chk_reset("rst");
    chk("rst_wrap_ce", {31'h0, fb1.rom_ce_o}, 32'h0);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    chk("c1_ce", {31'h0, fb0.rom_ce_o}, 32'h1);
    chk("c1_addr", fb0.rom_addr_o, 32'h0);
    chk("c1_valid", {31'h0, fb0.id_valid_o}, 32'h0);
    chk("wrap_a0", fb1.rom_addr_o, 32'hFFFF_FFF8);
    tick();
    chk_id("c2", 32'h0, 32'h0000_0093, 1'b1, 32'd1);
    chk("c2_addr", fb0.rom_addr_o, 32'h4);
    chk("wrap_a1", fb1.rom_addr_o, 32'hFFFF_FFFC);
    tick();
    chk_id("c3", 32'h4, 32'h0010_0113, 1'b1, 32'd2);
    chk("c3_addr", fb0.rom_addr_o, 32'h8);
    chk("wrap_a2", fb1.rom_addr_o, 32'h0000_0000);
    chk("wrap_mis", {31'h0, fb1.misalign_o}, 32'h0);
    chk("wrap_idpc", fb1.id_pc_o, 32'hFFFF_FFFC);

    // Two IF stalls at PC=8: bubbles, then PC 8 delivered once.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sif_addr", fb0.rom_addr_o, 32'h8);
      chk_id("sif", 32'h8, NOP, 1'b0, 32'd2);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_id("sif_rel", 32'h8, rom_word(32'h8), 1'b1, 32'd3);
    chk("sif_rel_addr", fb0.rom_addr_o, 32'hC);

    // ID stall together with IF stall: everything holds.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("sid_addr", fb0.rom_addr_o, 32'hC);
    chk_id("sid", 32'h8, rom_word(32'h8), 1'b1, 32'd3);

    // Redirect beats stall_id.
    drive(1'b0, 1'b1, 1'b1, 32'h40);
    tick();
    chk("br_addr", fb0.rom_addr_o, 32'h40);
    chk_id("br", 32'h0, NOP, 1'b0, 32'd3);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_id("br_tgt", 32'h40, rom_word(32'h40), 1'b1, 32'd4);
    chk("br_tgt_addr", fb0.rom_addr_o, 32'h44);

    // Reset during an IF stall at PC=0x20.
    drive(1'b0, 1'b0, 1'b1, 32'h20);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mid_addr", fb0.rom_addr_o, 32'h20);
    rst = 1'b1;
    tick();
    chk_reset("mid_rst");
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mid_ce", {31'h0, fb0.rom_ce_o}, 32'h1);
    chk("mid_addr0", fb0.rom_addr_o, 32'h0);
    chk("mid_valid", {31'h0, fb0.id_valid_o}, 32'h0);
    tick();
    chk_id("mid_first", 32'h0, 32'h0000_0093, 1'b1, 32'd1);

    // Misaligned redirect enters TRAP and freezes.
    drive(1'b0, 1'b0, 1'b1, 32'h42);
    tick();
    chk("trap_mis", {31'h0, fb0.misalign_o}, 32'h1);
    chk("trap_tpc", fb0.trap_pc_o, 32'h42);
    chk("trap_ce", {31'h0, fb0.rom_ce_o}, 32'h0);
    chk_id("trap", 32'h0, NOP, 1'b0, 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(i[0], i[1], 1'b1, 32'h80 + 32'(i));
      tick();
      chk("frz_mis", {31'h0, fb0.misalign_o}, 32'h1);
      chk("frz_tpc", fb0.trap_pc_o, 32'h42);
      chk("frz_ce", {31'h0, fb0.rom_ce_o}, 32'h0);
      chk_id("frz", 32'h0, NOP, 1'b0, 32'd1);
    end
    rst = 1'b1;
    tick();
    chk_reset("trap_rst");
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("post_ce", {31'h0, fb0.rom_ce_o}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
